led_matrix_scanner: RTL



---
 rtl/led_matrix_scanner_if.sv | 25 ++
 rtl/led_matrix_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner_if.sv
// Bus between the game/render logic and the LED matrix scanner.
// The upstream side writes shadow rows and requests frame swaps; the scanner
// drives the 74HC595 pin group and frame status back.
interface led_matrix_scanner_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       frame_swap;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe;
    logic [2:0] row_idx;
    logic       frame_done;

    modport master (
        output wr_en, wr_row, wr_data, frame_swap,
        input  ds, shcp, stcp, oe, row_idx, frame_done
    );

    modport slave (
        input  wr_en, wr_row, wr_data, frame_swap,
        output ds, shcp, stcp, oe, row_idx, frame_done
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-scan serializer for an 8x8 LED matrix behind two cascaded 74HC595s.
// Double-buffered: upstream writes the shadow buffer, the active buffer is
// shown, and the copy happens only at a frame boundary so frames never tear.
// Optional macro ROW_ACTIVE_LOW_EN inverts the row-select byte for
// common-anode boards; timing is unaffected.
module led_matrix_scanner #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned DISPLAY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    led_matrix_scanner_if.slave   bus
);
    localparam int unsigned CNT_MAX =
        (2 * CLK_DIV > DISPLAY_CYCLES) ? 2 * CLK_DIV : DISPLAY_CYCLES;
    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DISP_LAST  = CW'(DISPLAY_CYCLES - 1);

    typedef enum logic [1:0] {StLoad, StShift, StLatch, StDisplay} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [2:0]    row_q, row_d;
    logic [15:0]   word_q, word_d;
    logic [7:0]    row_sel;

    logic ds_q, ds_d;
    logic shcp_q, shcp_d;
    logic stcp_q, stcp_d;
    logic oe_q, oe_d;
    logic frame_done_q, frame_done_d;

    logic [7:0] shadow_q [8];
    logic [7:0] active_q [8];
    logic       swap_pending_q;

    // Next-state sequencing; pin levels are decoded from the next state so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        row_d   = row_q;
        word_d  = word_q;
        row_sel = 8'b1 << row_q;
`ifdef ROW_ACTIVE_LOW_EN
        row_sel = ~row_sel;
`endif
        case (state_q)
            StLoad: begin
                word_d  = {row_sel, active_q[row_q]};
                bit_d   = 4'd15;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd0) state_d = StLatch;
                    else               bit_d = bit_q - 4'd1;
                end
            end
            StLatch: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = StDisplay;
                end
            end
            StDisplay: begin
                if (cnt_q == DISP_LAST) begin
                    cnt_d   = '0;
                    row_d   = row_q + 3'd1;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase

        ds_d         = (state_d == StShift) ? word_d[bit_d] : 1'b0;
        shcp_d       = (state_d == StShift) && (cnt_d >= HALF);
        stcp_d       = (state_d == StLatch);
        oe_d         = (state_d != StDisplay);
        frame_done_d = (state_d == StDisplay) && (row_d == 3'd7) && (cnt_d == DISP_LAST);
    end

    // Scan state and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            bit_q        <= '0;
            row_q        <= '0;
            word_q       <= '0;
            ds_q         <= 1'b0;
            shcp_q       <= 1'b0;
            stcp_q       <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            row_q        <= row_d;
            word_q       <= word_d;
            ds_q         <= ds_d;
            shcp_q       <= shcp_d;
            stcp_q       <= stcp_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame buffers; the copy reads pre-edge shadow, so a write in the
    // frame_done cycle lands in shadow only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) begin
                shadow_q[r] <= 8'h00;
                active_q[r] <= 8'h00;
            end
            swap_pending_q <= 1'b0;
        end else begin
            if (bus.wr_en) shadow_q[bus.wr_row] <= bus.wr_data;
            if (frame_done_q && swap_pending_q) begin
                for (int r = 0; r < 8; r++) active_q[r] <= shadow_q[r];
                swap_pending_q <= bus.frame_swap;
            end else if (bus.frame_swap) begin
                swap_pending_q <= 1'b1;
            end
        end
    end

    assign bus.ds         = ds_q;
    assign bus.shcp       = shcp_q;
    assign bus.stcp       = stcp_q;
    assign bus.oe         = oe_q;
    assign bus.row_idx    = row_q;
    assign bus.frame_done = frame_done_q;
endmodule
